hazard_control_unit: RTL

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_control_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/hazard_control_unit.sv
// Hazard control for a 5-stage pipeline.
// Detects load-use hazards, squashes the ID instruction on taken branches, and
// freezes the whole pipeline while data memory is busy. A branch that resolves
// during a freeze is remembered and replayed as a single flush on release.
// Saturating counters record stall, flush and hold cycles.
module hazard_control_unit #(
    parameter int COUNT_W = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [4:0]         ID_rs1,
    input  logic [4:0]         ID_rs2,
    input  logic               ID_uses_rs1,
    input  logic               ID_uses_rs2,
    input  logic [4:0]         EX_rd,
    input  logic               EX_MemRead,
    input  logic               EX_RegWrite,
    input  logic               EX_branch_taken,
    input  logic               mem_busy,
    output logic               PC_write,
    output logic               IFID_write,
    output logic               IFID_flush,
    output logic               IDEX_write,
    output logic               IDEX_bubble,
    output logic [1:0]         state,
    output logic [COUNT_W-1:0] stall_count,
    output logic [COUNT_W-1:0] flush_count,
    output logic [COUNT_W-1:0] hold_count
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_HOLD       = 2'b01,
        ST_FLUSH_PEND = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] stall_count_q, stall_count_d;
    logic [COUNT_W-1:0] flush_count_q, flush_count_d;
    logic [COUNT_W-1:0] hold_count_q, hold_count_d;

    logic lu_s;
    logic stall_evt_s;
    logic flush_evt_s;
    logic hold_evt_s;

    // EX_RegWrite is part of the pipeline interface but a load always writes,
    // so EX_MemRead alone qualifies the load-use check.
    logic unused_s;
    assign unused_s = EX_RegWrite;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(
        input logic [COUNT_W-1:0] value,
        input logic               enable
    );
        logic [COUNT_W-1:0] result;
        if (enable && (value != {COUNT_W{1'b1}})) begin
            result = value + {{(COUNT_W-1){1'b0}}, 1'b1};
        end else begin
            result = value;
        end
        return result;
    endfunction

    // Load-use hazard: the loaded register is read by the instruction in ID.
    always_comb begin
        lu_s = EX_MemRead && (EX_rd != 5'd0) &&
               ((ID_uses_rs1 && (ID_rs1 == EX_rd)) ||
                (ID_uses_rs2 && (ID_rs2 == EX_rd)));
    end

    // Next state, pipeline control outputs and counter events.
    always_comb begin
        state_d     = state_q;
        PC_write    = 1'b1;
        IFID_write  = 1'b1;
        IFID_flush  = 1'b0;
        IDEX_write  = 1'b1;
        IDEX_bubble = 1'b0;
        stall_evt_s = 1'b0;
        flush_evt_s = 1'b0;
        hold_evt_s  = 1'b0;

        if (!reset_n) begin
            // Fill the pipeline with NOPs while the PC is held.
            state_d     = ST_RUN;
            PC_write    = 1'b0;
            IFID_write  = 1'b1;
            IFID_flush  = 1'b1;
            IDEX_write  = 1'b1;
            IDEX_bubble = 1'b1;
        end else if (mem_busy) begin
            // Freeze everything; a branch seen now is deferred, not acted on.
            PC_write    = 1'b0;
            IFID_write  = 1'b0;
            IDEX_write  = 1'b0;
            hold_evt_s  = 1'b1;
            case (state_q)
                ST_RUN:        state_d = EX_branch_taken ? ST_FLUSH_PEND : ST_HOLD;
                ST_HOLD:       state_d = EX_branch_taken ? ST_FLUSH_PEND : ST_HOLD;
                ST_FLUSH_PEND: state_d = ST_FLUSH_PEND;
                default:       state_d = ST_RUN;
            endcase
        end else begin
            // Memory ready: every state behaves as RUN, with a pending flush
            // taking effect exactly once on this release cycle.
            state_d = ST_RUN;
            if ((state_q == ST_FLUSH_PEND) || EX_branch_taken) begin
                IFID_flush  = 1'b1;
                IDEX_bubble = 1'b1;
                flush_evt_s = 1'b1;
            end else if (lu_s) begin
                PC_write    = 1'b0;
                IFID_write  = 1'b0;
                IDEX_bubble = 1'b1;
                stall_evt_s = 1'b1;
            end else begin
                stall_evt_s = 1'b0;
            end
        end
    end

    // Counter next values; reset clears them regardless of events.
    always_comb begin
        if (!reset_n) begin
            stall_count_d = {COUNT_W{1'b0}};
            flush_count_d = {COUNT_W{1'b0}};
            hold_count_d  = {COUNT_W{1'b0}};
        end else begin
            stall_count_d = sat_inc(stall_count_q, stall_evt_s);
            flush_count_d = sat_inc(flush_count_q, flush_evt_s);
            hold_count_d  = sat_inc(hold_count_q, hold_evt_s);
        end
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= ST_RUN;
            stall_count_q <= {COUNT_W{1'b0}};
            flush_count_q <= {COUNT_W{1'b0}};
            hold_count_q  <= {COUNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
            hold_count_q  <= hold_count_d;
        end
    end

    assign state       = state_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
    assign hold_count  = hold_count_q;

endmodule
